ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 keyboard port; the opposite direction of the existing PS/2 keyboard receiver.
- Sends one command byte to the keyboard, e.g. 0xED for set-LEDs or 0xFF for reset.
- Drives the open-collector clock and data lines through drive-low enables. The top level builds the tristates and shares the input pins with the receiver.
- Reports completion, device ACK/NACK and timeout to game control logic.

Parameters:
- INHIBIT_CYCLES, 10000: system-clock cycles the host holds ps2_clk low (100 us at 100 MHz).
- REQ_CYCLES, 16: cycles both lines are held low before ps2_clk is released.
- TIMEOUT_CYCLES, 2000000: maximum system-clock cycles without a ps2_clk falling edge (20 ms).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- data_in  in  8  command byte, latched when start is accepted
- ps2_clk_i  in  1  PS/2 clock pin value, asynchronous
- ps2_data_i  in  1  PS/2 data pin value, asynchronous
- ps2_clk_oe  out  1  1 = pull ps2_clk low; 0 = release
- ps2_data_oe  out  1  1 = pull ps2_data low; 0 = release
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of transfer (success or error)
- ack_err  out  1  device NACK; valid with done, held until next accepted start
- timeout_err  out  1  timeout; valid with done, held until next accepted start

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs are 0, state is IDLE and the counters clear.
  - Both lines are released on the edge after rst. This also applies to reset mid-transfer; no done pulse is produced.
- Synchronisation:
  - ps2_clk_i and ps2_data_i each pass through a 2-FF synchroniser.
  - A falling edge (fe) is a 1->0 transition on the synchronised clock, registered. fe lags the pin by 3 clk cycles.
- Accepting a request: in IDLE, start=1 latches data_in and computes parity = ~^data_in (odd parity). It clears ack_err and timeout_err and moves to INHIBIT. start is ignored in all other states.
- States and transitions:
  - INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
  - REQ: ps2_clk_oe=1, ps2_data_oe=1 (start bit 0) for REQ_CYCLES cycles, then SEND with bit index k=0.
  - SEND: ps2_clk_oe=0. Each fe updates ps2_data_oe on the next cycle; k increments per fe:
    - k=0..7: ps2_data_oe = ~data[k], LSB first.
    - k=8: ps2_data_oe = ~parity.
    - k=9: ps2_data_oe=0 (stop bit, line released), then WAIT_ACK.
  - Between edges ps2_data_oe is held constant; the device samples on the rising edge.
  - WAIT_ACK: on the next fe, sample synchronised data. 0 means ACK; 1 sets ack_err=1. Then WAIT_IDLE.
  - WAIT_IDLE: wait until both synchronised lines read 1 in the same cycle. Next cycle: done=1 for one cycle, busy=0, back to IDLE.
- Timeout:
  - The counter is active in SEND, WAIT_ACK and WAIT_IDLE. It clears on entry to SEND and on every fe.
  - When it reaches TIMEOUT_CYCLES-1: release both lines, timeout_err=1, done pulse on the next cycle, then IDLE.
  - Timeout takes priority over a simultaneous fe.
- Fixed rules:
  - ps2_clk_oe is never asserted outside INHIBIT/REQ.
  - ps2_data_oe is never asserted in IDLE, WAIT_ACK or WAIT_IDLE.
  - Latency from start to first ps2_clk_oe=1 is 1 cycle.
- Extra edges after ACK (device misbehaviour) are ignored; WAIT_IDLE only watches line levels.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz and ACKs.
  - Bits sampled on rising edges are 1,0,1,1,0,1,1,1, then parity 1 and stop 1.
  - Clock inhibit lasts exactly 10000 cycles.
  - done pulses once; ack_err=0, timeout_err=0.
- Send 0x00 -> parity bit 1. Send 0xFF -> parity bit 1. Send 0x01 -> parity bit 0. Device ACKs in all three cases.
- Device holds data high in the ACK slot -> done pulse with ack_err=1, timeout_err=0; both oe signals are 0 afterwards.
- Device never clocks after REQ -> exactly TIMEOUT_CYCLES after entering SEND, timeout_err=1, done=1, both oe signals are 0.
- start pulses during INHIBIT and mid-SEND -> ignored; the byte transmitted is the first data_in, and exactly one done pulse occurs.
- rst asserted after bit 4 -> both oe signals are 0 and busy=0 on the next cycle, no done pulse; a following start of 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// ps2_host_tx : PS/2 host-to-device command byte transmitter
//               (open-collector drive-low enables, ACK/NACK and timeout)
// Revision    : 1.0
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int REQ_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int c_max_cycles =
    (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
      ((TIMEOUT_CYCLES > REQ_CYCLES) ? TIMEOUT_CYCLES : REQ_CYCLES) :
      ((INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES);
  localparam int c_cnt_w = $clog2(c_max_cycles + 1);

  localparam logic [c_cnt_w-1:0] c_inhibit_last = c_cnt_w'(INHIBIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_req_last     = c_cnt_w'(REQ_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [3:0]         bit_q, bit_d;
  logic [7:0]         data_q, data_d;
  logic               parity_q, parity_d;
  logic               clk_oe_q, clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ack_err_q, ack_err_d;
  logic               timeout_err_q, timeout_err_d;
  logic               clk_meta_q, clk_meta_d;
  logic               clk_sync_q, clk_sync_d;
  logic               clk_prev_q, clk_prev_d;
  logic               data_meta_q, data_meta_d;
  logic               data_sync_q, data_sync_d;
  logic               fe_q, fe_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    data_d        = data_q;
    parity_d      = parity_q;
    clk_oe_d      = clk_oe_q;
    data_oe_d     = data_oe_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ack_err_d     = ack_err_q;
    timeout_err_d = timeout_err_q;

    clk_meta_d  = ps2_clk_i;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2_data_i;
    data_sync_d = data_meta_q;
    fe_d        = clk_prev_q & ~clk_sync_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d        = data_in;
          parity_d      = ~^data_in;
          ack_err_d     = 1'b0;
          timeout_err_d = 1'b0;
          busy_d        = 1'b1;
          clk_oe_d      = 1'b1;
          data_oe_d     = 1'b0;
          cnt_d         = '0;
          state_d       = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == c_inhibit_last) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_REQ: begin
        // Releasing the clock with data held low presents the start bit.
        if (cnt_q == c_req_last) begin
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          bit_d    = 4'd0;
          state_d  = S_SEND;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_SEND, S_WAIT_ACK, S_WAIT_IDLE: begin
        if (cnt_q == c_timeout_last) begin
          clk_oe_d      = 1'b0;
          data_oe_d     = 1'b0;
          timeout_err_d = 1'b1;
          done_d        = 1'b1;
          busy_d        = 1'b0;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = fe_q ? '0 : cnt_q + c_cnt_one;
          case (state_q)
            S_SEND: begin
              if (fe_q) begin
                if (bit_q < 4'd8) begin
                  data_oe_d = ~data_q[bit_q[2:0]];
                end else if (bit_q == 4'd8) begin
                  data_oe_d = ~parity_q;
                end else begin
                  data_oe_d = 1'b0;
                  state_d   = S_WAIT_ACK;
                end
                bit_d = bit_q + 4'd1;
              end
            end
            S_WAIT_ACK: begin
              if (fe_q) begin
                ack_err_d = data_sync_q;
                state_d   = S_WAIT_IDLE;
              end
            end
            S_WAIT_IDLE: begin
              // Only line levels matter here; stray clock edges are ignored.
              if (clk_sync_q && data_sync_q) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
              end
            end
            default: begin
            end
          endcase
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= 4'd0;
      data_q        <= 8'd0;
      parity_q      <= 1'b0;
      clk_oe_q      <= 1'b0;
      data_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      clk_meta_q    <= 1'b1;
      clk_sync_q    <= 1'b1;
      clk_prev_q    <= 1'b1;
      data_meta_q   <= 1'b1;
      data_sync_q   <= 1'b1;
      fe_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      data_q        <= data_d;
      parity_q      <= parity_d;
      clk_oe_q      <= clk_oe_d;
      data_oe_q     <= data_oe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
      clk_meta_q    <= clk_meta_d;
      clk_sync_q    <= clk_sync_d;
      clk_prev_q    <= clk_prev_d;
      data_meta_q   <= data_meta_d;
      data_sync_q   <= data_sync_d;
      fe_q          <= fe_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// tb_ps2_host_tx : directed + randomized bench with a PS/2 device model
// Revision       : 1.0
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH = 200;
  localparam int REQ = 16;
  localparam int TO  = 3000;
  localparam int H   = 40;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic       ps2_clk_line;
  logic       ps2_data_line;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;
  logic       dev_clk_low;
  logic       dev_data_low;

  int n_cmp  = 0;
  int n_fail = 0;

  int done_cnt   = 0;
  bit done_ack_q = 1'b0;
  bit done_to_q  = 1'b0;
  int inh_run    = 0;
  int inh_last   = 0;
  int req_run    = 0;
  int req_last   = 0;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .ps2_clk_i   (ps2_clk_line),
    .ps2_data_i  (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counter and phase-length recorders observed mid-cycle.
  always @(negedge clk) begin
    if (done) begin
      done_cnt   <= done_cnt + 1;
      done_ack_q <= ack_err;
      done_to_q  <= timeout_err;
    end
    if (ps2_clk_oe && !ps2_data_oe) inh_run <= inh_run + 1;
    else if (inh_run != 0) begin
      inh_last <= inh_run;
      inh_run  <= 0;
    end
    if (ps2_clk_oe && ps2_data_oe) req_run <= req_run + 1;
    else if (req_run != 0) begin
      req_last <= req_run;
      req_run  <= 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected frame as seen on the wire: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int v;
    int ones;
    logic [10:0] f;
    v    = int'(d);
    ones = 0;
    f    = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = ((v % 2) == 1);
      ones   = ones + (v % 2);
      v      = v / 2;
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic issue_start(input logic [7:0] d);
    start   = 1'b1;
    data_in = d;
    tick(1);
    start   = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic device(input bit nack, input int inject_bit, input int abort_bit,
                        output logic [10:0] bits, output bit aborted);
    bit seen;
    int n;
    bits    = '0;
    aborted = 1'b0;
    seen    = 1'b0;
    n       = 0;
    while (!seen && n < 2000) begin
      tick(1);
      n++;
      if (busy && !ps2_clk_oe && ps2_data_oe) seen = 1'b1;
    end
    check("req_seen", 32'(seen), 32'd1);
    if (!seen) return;
    check("busy_in_send", 32'(busy), 32'd1);
    tick(H);
    bits[0] = ps2_data_line;
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == inject_bit) begin
        start   = 1'b1;
        data_in = 8'h5A;
        tick(1);
        start   = 1'b0;
        tick(H - 1);
      end else begin
        tick(H);
      end
      dev_clk_low = 1'b0;
      bits[i+1]   = ps2_data_line;
      if (i == abort_bit) begin
        aborted = 1'b1;
        return;
      end
      tick(H);
    end
    tick(H / 2);
    dev_data_low = !nack;
    tick(H / 2);
    dev_clk_low  = 1'b1;
    tick(H);
    dev_clk_low  = 1'b0;
    tick(H / 2);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 1000) begin
      tick(1);
      n++;
    end
    check("done_seen", 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit nack, input int inject_bit);
    logic [10:0] bits;
    bit ab;
    int d0;
    d0 = done_cnt;
    issue_start(d);
    check("start_latency_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared", 32'({ack_err, timeout_err}), 32'd0);
    if (inject_bit >= 0) begin
      tick(50);
      start   = 1'b1;
      data_in = ~d;
      tick(1);
      start   = 1'b0;
    end
    device(nack, inject_bit, -1, bits, ab);
    wait_done(d0);
    check("frame", 32'(bits), 32'(model_frame(d)));
    check("ack_err_at_done", 32'(done_ack_q), 32'(nack));
    check("timeout_err_at_done", 32'(done_to_q), 32'd0);
    tick(2);
    check("oe_after_done", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("ack_err_held", 32'(ack_err), 32'(nack));
    check("inhibit_len", 32'(inh_last), 32'(INH));
    check("req_len", 32'(req_last), 32'(REQ));
    check("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    int n;
    int cycles;
    bit seen;
    bit got;
    bit ab;
    logic [10:0] bits;
    logic [7:0] rb;
    bit rn;

    rst          = 1'b1;
    start        = 1'b0;
    data_in      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    tick(3);
    check("reset_outputs",
          32'({ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err}), 32'd0);
    rst = 1'b0;
    tick(2);

    run_xfer(8'hED, 1'b0, -1);
    run_xfer(8'h00, 1'b0, -1);
    run_xfer(8'hFF, 1'b0, -1);
    run_xfer(8'h01, 1'b0, -1);
    run_xfer(8'hA7, 1'b1, -1);

    // Device never clocks: timeout measured from the first cycle in SEND.
    d0 = done_cnt;
    issue_start(8'h42);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 2000) begin
      tick(1);
      n++;
      if (busy && !ps2_clk_oe && ps2_data_oe) seen = 1'b1;
    end
    check("to_send_seen", 32'(seen), 32'd1);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < TO + 100) begin
      tick(1);
      cycles++;
      if (done) got = 1'b1;
    end
    check("timeout_cycles", 32'(cycles), 32'(TO));
    check("timeout_err", 32'(timeout_err), 32'd1);
    check("timeout_ack_err", 32'(ack_err), 32'd0);
    check("timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    tick(2);
    check("timeout_done_count", 32'(done_cnt - d0), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);

    run_xfer(8'h96, 1'b0, 3);

    // Reset in the middle of a frame.
    d0 = done_cnt;
    issue_start(8'h3C);
    device(1'b0, -1, 4, bits, ab);
    check("abort_reached", 32'(ab), 32'd1);
    rst = 1'b1;
    tick(1);
    check("rst_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(20);
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    run_xfer(8'hF4, 1'b0, -1);

    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      rn = ($urandom_range(0, 3) == 0);
      run_xfer(rb, rn, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
